// File: rtl/axis_pattern_pkg.sv
// -----------------------------------------------------------------------------
// axis_pattern_pkg
// Shared definitions for the AXI-Stream frame monitor:
//   PAT_HI / KEEP_ALL  - constant parts of every generator beat
//   axis_beat_t        - one stream beat as stored in the skid buffer
//   beat_check_t       - per-beat check results produced by the monitor
//   pat_word()         - expected tdata for a given beat index
// -----------------------------------------------------------------------------
package axis_pattern_pkg;

  localparam logic [23:0] PAT_HI   = 24'hAAAAAA;
  localparam logic [3:0]  KEEP_ALL = 4'hF;

  // Beat index width: frames are at most 256 words long.
  localparam int IDX_W = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
  } axis_beat_t;

  localparam int BEAT_W = $bits(axis_beat_t);

  typedef struct packed {
    logic data_bad;
    logic keep_bad;
    logic len_bad;
  } beat_check_t;

  // The generator emits a fixed upper 24 bits and the beat index in the low byte.
  function automatic logic [31:0] pat_word(input logic [IDX_W-1:0] idx);
    return {PAT_HI, idx};
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// -----------------------------------------------------------------------------
// axis_skid_buf
// Two-entry skid buffer with a registered upstream ready.
//
// Handshake (both sides): a beat moves on a rising clk edge where valid and
// ready are both high. The sender keeps valid and its payload stable until
// that edge; ready never depends combinationally on valid.
//
// Entry "out" drives the downstream port; entry "skid" catches the one beat
// that can arrive while "out" is stalled, because s_ready is a flop and can
// only fall one cycle after the buffer fills.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   s_data/valid/ready upstream side, WIDTH-bit payload
//   m_data/valid/ready downstream side, WIDTH-bit payload
// -----------------------------------------------------------------------------
module axis_skid_buf #(
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] out_data,  out_data_n;
  logic [WIDTH-1:0] skid_data, skid_data_n;
  logic             out_valid, out_valid_n;
  logic             skid_valid, skid_valid_n;
  logic             ready_q,   ready_n;
  logic             s_fire;

  assign s_fire = s_valid & ready_q;

  always_comb begin
    out_data_n   = out_data;
    out_valid_n  = out_valid;
    skid_data_n  = skid_data;
    skid_valid_n = skid_valid;

    if (!out_valid || m_ready) begin
      // Output slot frees up this cycle: refill it, oldest beat first.
      if (skid_valid) begin
        out_data_n   = skid_data;
        out_valid_n  = 1'b1;
        skid_valid_n = s_fire;
        if (s_fire) begin
          skid_data_n = s_data;
        end
      end else begin
        out_valid_n = s_fire;
        if (s_fire) begin
          out_data_n = s_data;
        end
      end
    end else if (s_fire) begin
      // Output is stalled: park the incoming beat in the skid entry.
      skid_valid_n = 1'b1;
      skid_data_n  = s_data;
    end

    // Ready for next cycle is decided from next-cycle occupancy, so it is a flop.
    ready_n = !(out_valid_n && skid_valid_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      out_data   <= out_data_n;
      out_valid  <= out_valid_n;
      skid_data  <= skid_data_n;
      skid_valid <= skid_valid_n;
      ready_q    <= ready_n;
    end
  end

  assign s_ready = ready_q;
  assign m_data  = out_data;
  assign m_valid = out_valid;

endmodule

// File: rtl/axis_frame_monitor.sv
// -----------------------------------------------------------------------------
// axis_frame_monitor
// In-line checker between the 32-bit test-pattern generator and the S2MM DMA.
// Every beat is forwarded unchanged through a 2-entry skid buffer. Each input
// handshake is checked against the generator pattern and the frame length,
// and saturating statistics plus sticky error flags are published.
//
// Handshake: AXI-Stream rules on both ports -- a beat transfers on a rising
// aclk edge with tvalid and tready both high; tready is a register output.
//
// Ports
//   aclk, areset           clock, asynchronous active-high reset
//   s_axis_*               32-bit stream from the generator
//   m_axis_*               32-bit stream to the S2MM DMA (1-cycle latency)
//   clr_stats              1-cycle pulse; counters/flags reload this cycle's event
//   frame_cnt              frames closed (tlast beat or forced boundary)
//   err_frame_cnt          closed frames that contained at least one error
//   data_err/len_err/keep_err  sticky error flags
// Parameters
//   BYTES_PER_BLOCK        frame length in bytes, multiple of 4, 4..1024
//   CNT_W                  width of each statistics counter
// -----------------------------------------------------------------------------
module axis_frame_monitor
  import axis_pattern_pkg::*;
#(
  parameter int BYTES_PER_BLOCK = 64,
  parameter int CNT_W           = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic [3:0]       s_axis_tkeep,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [3:0]       m_axis_tkeep,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_frame_cnt,
  output logic             data_err,
  output logic             len_err,
  output logic             keep_err
);

  localparam int               WPB      = BYTES_PER_BLOCK / 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Datapath: pure pass-through via the skid buffer.
  // ---------------------------------------------------------------------------
  axis_beat_t in_beat;
  axis_beat_t out_beat;

  assign in_beat = '{data: s_axis_tdata, last: s_axis_tlast, keep: s_axis_tkeep};

  axis_skid_buf #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk     (aclk),
    .rst     (areset),
    .s_data  (in_beat),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (out_beat),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign m_axis_tdata = out_beat.data;
  assign m_axis_tlast = out_beat.last;
  assign m_axis_tkeep = out_beat.keep;

  // ---------------------------------------------------------------------------
  // Checker: observes the input handshake only, never feeds back into it.
  // ---------------------------------------------------------------------------
  logic             s_fire;
  logic [IDX_W-1:0] idx, idx_n;
  logic             frame_bad, frame_bad_n;  // an error was seen earlier in this frame
  beat_check_t      chk;
  logic             beat_bad;
  logic             at_end;
  logic             frame_ev;                // a frame closes on this beat
  logic             err_ev;                  // ...and that frame had an error

  assign s_fire = s_axis_tvalid & s_axis_tready;

  always_comb begin
    chk         = '0;
    beat_bad    = 1'b0;
    at_end      = (idx == LAST_IDX);
    frame_ev    = 1'b0;
    err_ev      = 1'b0;
    idx_n       = idx;
    frame_bad_n = frame_bad;

    if (s_fire) begin
      chk.data_bad = (s_axis_tdata != pat_word(idx));
      chk.keep_bad = (s_axis_tkeep != KEEP_ALL);
      // Covers both an early tlast and a missing one on the last word.
      chk.len_bad  = (s_axis_tlast != at_end);
      beat_bad     = chk.data_bad | chk.keep_bad | chk.len_bad;

      // A missing tlast still closes the frame so the index resynchronises.
      frame_ev = s_axis_tlast | at_end;
      err_ev   = frame_ev & (frame_bad | beat_bad);

      if (frame_ev) begin
        idx_n       = '0;
        frame_bad_n = 1'b0;
      end else begin
        idx_n       = idx + 1'b1;
        frame_bad_n = frame_bad | beat_bad;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      idx       <= '0;
      frame_bad <= 1'b0;
    end else begin
      idx       <= idx_n;
      frame_bad <= frame_bad_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics. A clear reloads with this cycle's event so nothing is lost
  // when a clear and an event coincide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_cnt     <= '0;
      err_frame_cnt <= '0;
      data_err      <= 1'b0;
      len_err       <= 1'b0;
      keep_err      <= 1'b0;
    end else if (clr_stats) begin
      frame_cnt     <= CNT_W'(frame_ev);
      err_frame_cnt <= CNT_W'(err_ev);
      data_err      <= chk.data_bad;
      len_err       <= chk.len_bad;
      keep_err      <= chk.keep_bad;
    end else begin
      if (frame_ev && (frame_cnt != CNT_MAX)) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (err_ev && (err_frame_cnt != CNT_MAX)) begin
        err_frame_cnt <= err_frame_cnt + 1'b1;
      end
      data_err <= data_err | chk.data_bad;
      len_err  <= len_err  | chk.len_bad;
      keep_err <= keep_err | chk.keep_bad;
    end
  end

endmodule

// File: tb/tb_axis_frame_monitor.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_monitor
// Directed vector table, hand sequences for reset and saturation, and a
// randomized phase. A negedge monitor keeps a frame-level reference model and
// an expected-beat queue for the pass-through path.
// -----------------------------------------------------------------------------
module tb_axis_frame_monitor;

  localparam int BPB     = 64;
  localparam int WPB     = BPB / 4;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------------------------------------------------------- clock/reset
  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic [31:0]      s_axis_tdata = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic             s_axis_tlast = 1'b0;
  logic [3:0]       s_axis_tkeep = '0;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b1;
  logic             m_axis_tlast;
  logic [3:0]       m_axis_tkeep;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_frame_cnt;
  logic             data_err;
  logic             len_err;
  logic             keep_err;

  always #5 aclk = ~aclk;

  axis_frame_monitor #(
    .BYTES_PER_BLOCK (BPB),
    .CNT_W           (CNT_W)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tkeep  (s_axis_tkeep),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .clr_stats     (clr_stats),
    .frame_cnt     (frame_cnt),
    .err_frame_cnt (err_frame_cnt),
    .data_err      (data_err),
    .len_err       (len_err),
    .keep_err      (keep_err)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] lo;
    lo = i[7:0];
    return {24'hAAAAAA, lo};
  endfunction

  // Downstream ready: 0 = always ready, 1 = ~30% stalls, 2 = fully stalled.
  int rdy_mode = 0;
  initial forever begin
    @(posedge aclk);
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 99) >= 30);
      default: m_axis_tready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- scoreboard + model
  logic [36:0] exp_q[$];           // {data, last, keep} in expected output order
  logic [31:0] fr_data[$];         // beats of the frame currently open
  logic [3:0]  fr_keep[$];
  int          m_frames = 0, m_errs = 0;
  bit          m_derr = 0, m_lerr = 0, m_kerr = 0;
  int          occ = 0;            // beats accepted but not yet delivered
  bit          stall_prev = 0;
  bit          post_rst = 0;
  logic [36:0] held;

  // Frame-level reference: a frame is judged as a whole when it closes.
  task automatic model_step(input bit fire, input logic [31:0] d, input bit l,
                            input logic [3:0] k, input bit clr);
    bit fev, eev, dev, kev, lev;
    int pos;
    fev = 0; eev = 0; dev = 0; kev = 0; lev = 0;
    if (fire) begin
      pos = fr_data.size();
      fr_data.push_back(d);
      fr_keep.push_back(k);
      dev = (d != pat(pos));
      kev = (k != 4'hF);
      lev = l && (pos != WPB - 1);
      if (l || pos == WPB - 1) begin
        fev = 1;
        lev = (pos != WPB - 1) || !l;
        eev = lev;
        foreach (fr_data[i]) if (fr_data[i] != pat(i) || fr_keep[i] != 4'hF) eev = 1;
        fr_data.delete();
        fr_keep.delete();
      end
    end
    if (clr) begin
      m_frames = int'(fev); m_errs = int'(eev);
      m_derr = dev; m_lerr = lev; m_kerr = kev;
    end else begin
      if (fev && m_frames < CNT_MAX) m_frames++;
      if (eev && m_errs < CNT_MAX) m_errs++;
      m_derr |= dev; m_lerr |= lev; m_kerr |= kev;
    end
  endtask

  always @(negedge aclk) begin
    if (areset) begin
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_s_tready", s_axis_tready, 0);
      exp_q.delete(); fr_data.delete(); fr_keep.delete();
      m_frames = 0; m_errs = 0; m_derr = 0; m_lerr = 0; m_kerr = 0;
      occ = 0; stall_prev = 0; post_rst = 1;
    end else begin
      check("mon_frame_cnt", frame_cnt, m_frames);
      check("mon_err_frame_cnt", err_frame_cnt, m_errs);
      check("mon_flags", {data_err, len_err, keep_err}, {m_derr, m_lerr, m_kerr});
      check("mon_m_tvalid", m_axis_tvalid, occ > 0);
      check("mon_s_tready", s_axis_tready, (occ < 2) && !post_rst);
      if (stall_prev) check("mon_stall_stable", {m_axis_tdata, m_axis_tlast, m_axis_tkeep}, held);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) check("mon_out_unexpected", 1, 0);
        else check("mon_out_beat", {m_axis_tdata, m_axis_tlast, m_axis_tkeep}, exp_q.pop_front());
        occ--;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back({s_axis_tdata, s_axis_tlast, s_axis_tkeep});
        occ++;
      end
      model_step(s_axis_tvalid && s_axis_tready, s_axis_tdata, s_axis_tlast, s_axis_tkeep, clr_stats);
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held       = {m_axis_tdata, m_axis_tlast, m_axis_tkeep};
      post_rst   = 0;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  // All tasks start and end at 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic send_beat(input logic [31:0] d, input bit l, input logic [3:0] k, input bit c);
    bit done;
    done = 0;
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tkeep = k;
    s_axis_tvalid = 1'b1; clr_stats = c;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge aclk);
      if (s_axis_tready) done = 1;
      @(posedge aclk); #1;
    end
    check("send_beat_accepted", done, 1);
    s_axis_tvalid = 1'b0; clr_stats = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("rel_s_tready_before_clk", s_axis_tready, 0);
    check("rel_m_beat", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tkeep}, 0);
    check("rel_counters", {frame_cnt, err_frame_cnt}, 0);
    check("rel_flags", {data_err, len_err, keep_err}, 0);
    @(posedge aclk); #1;
    check("rel_s_tready_after_clk", s_axis_tready, 1);
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0; clr_stats = 1'b0;
    areset = 1'b1;
    release_reset();
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (exp_q.size() > 0); t++) idle(1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clean_frame();
    for (int b = 0; b < WPB; b++) send_beat(pat(b), b == WPB - 1, 4'hF, 0);
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic [31:0] data;
    bit          last;
    logic [3:0]  keep;
    bit          clr;
    bit          rst;          // reset before applying this beat
    bit          e_d, e_l, e_k;
    int          e_fc, e_efc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [31:0] d, input bit l, input logic [3:0] k, input bit c,
                     input bit r, input bit ed, input bit el, input bit ek,
                     input int fc, input int efc);
    vec_t v;
    v.data = d; v.last = l; v.keep = k; v.clr = c; v.rst = r;
    v.e_d = ed; v.e_l = el; v.e_k = ek; v.e_fc = fc; v.e_efc = efc;
    tbl.push_back(v);
  endtask

  // ---------------------------------------------------------------- main
  logic [31:0] d;
  logic [3:0]  k;
  bit          l, c;
  int          gen_i, r, j;

  initial begin
    // Clean frames: three frames of 16 beats.
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < WPB; b++)
        add(pat(b), b == 15, 4'hF, 0, f == 0 && b == 0, 0, 0, 0, f + int'(b == 15), 0);
    // Early tlast on beat 9, then a clean frame starting at index 0.
    for (int b = 0; b < 10; b++)
      add(pat(b), b == 9, 4'hF, 0, b == 0, 0, b == 9, 0, int'(b == 9), int'(b == 9));
    for (int b = 0; b < WPB; b++)
      add(pat(b), b == 15, 4'hF, 0, 0, 0, 1, 0, 1 + int'(b == 15), 1);
    // Missing tlast on beat 15 plus corrupted beat 3.
    for (int b = 0; b < WPB; b++)
      add(b == 3 ? 32'hAAAA5503 : pat(b), 0, 4'hF, 0, b == 0,
          b >= 3, b == 15, 0, int'(b == 15), int'(b == 15));
    // tkeep error on beat 0, then a clean frame whose tlast coincides with clr_stats.
    for (int b = 0; b < WPB; b++)
      add(pat(b), b == 15, b == 0 ? 4'h7 : 4'hF, 0, b == 0, 0, 0, 1, int'(b == 15), int'(b == 15));
    for (int b = 0; b < WPB; b++)
      add(pat(b), b == 15, 4'hF, b == 15, 0, 0, 0, b != 15, 1, int'(b != 15));

    do_reset();
    rdy_mode = 0;
    idle(1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      send_beat(tbl[i].data, tbl[i].last, tbl[i].keep, tbl[i].clr);
      check($sformatf("v%0d_data_err", i), data_err, tbl[i].e_d);
      check($sformatf("v%0d_len_err", i), len_err, tbl[i].e_l);
      check($sformatf("v%0d_keep_err", i), keep_err, tbl[i].e_k);
      check($sformatf("v%0d_frame_cnt", i), frame_cnt, tbl[i].e_fc);
      check($sformatf("v%0d_err_frame_cnt", i), err_frame_cnt, tbl[i].e_efc);
    end
    drain();

    // Reset mid-frame: beat 5 parked at the output, beat 6 presented.
    do_reset();
    clean_frame();
    for (int b = 0; b < 5; b++) send_beat(pat(b), 0, 4'hF, 0);
    rdy_mode = 2;
    idle(2);
    send_beat(pat(5), 0, 4'hF, 0);
    check("mid_rst_m_tvalid_before", m_axis_tvalid, 1);
    check("mid_rst_frame_cnt_before", frame_cnt, 1);
    s_axis_tdata = pat(6); s_axis_tlast = 0; s_axis_tkeep = 4'hF; s_axis_tvalid = 1;
    #2;
    areset = 1'b1;
    #1;
    check("mid_rst_m_tvalid_async", m_axis_tvalid, 0);
    check("mid_rst_s_tready_async", s_axis_tready, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    s_axis_tvalid = 0;
    rdy_mode = 0;
    release_reset();
    clean_frame();
    drain();
    check("mid_rst_restart_cnt", {frame_cnt, err_frame_cnt}, {6'd1, 6'd0});
    check("mid_rst_restart_flags", {data_err, len_err, keep_err}, 0);

    // Backpressure: 5 clean frames with ~30% downstream stalls.
    do_reset();
    rdy_mode = 1;
    for (int f = 0; f < 5; f++) clean_frame();
    drain();
    check("bp_frame_cnt", frame_cnt, 5);
    check("bp_err_and_flags", {err_frame_cnt, data_err, len_err, keep_err}, 0);

    // Random stream with occasional corruption, bad keep, wrong tlast, clears.
    gen_i = 0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      d = pat(gen_i); k = 4'hF; l = (gen_i == WPB - 1);
      if (r < 4) begin j = $urandom_range(0, 31); d[j] = ~d[j]; end
      else if (r < 7) k = 4'($urandom_range(0, 14));
      else if (r < 10) l = ~l;
      c = ($urandom_range(0, 49) == 0);
      send_beat(d, l, k, c);
      gen_i = (l || gen_i == WPB - 1) ? 0 : gen_i + 1;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    drain();

    // Saturation: 70 one-beat frames, each with an early tlast.
    do_reset();
    for (int n = 0; n < 70; n++) send_beat(pat(0), 1, 4'hF, 0);
    idle(1);
    check("sat_frame_cnt", frame_cnt, CNT_MAX);
    check("sat_err_frame_cnt", err_frame_cnt, CNT_MAX);
    check("sat_flags", {data_err, len_err, keep_err}, 3'b010);
    clr_stats = 1'b1;
    idle(1);
    clr_stats = 1'b0;
    check("clr_only_counters", {frame_cnt, err_frame_cnt}, 0);
    check("clr_only_flags", {data_err, len_err, keep_err}, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_miss);
    $fatal(1, "watchdog expired");
  end

endmodule
